fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
Shares the single-port framebuffer RAM (214x160 pixels, 3-bit RGB) between the VGA scanout reader and the CPU pixel read/write port. Scanout has fixed priority and a bounded fetch latency. The CPU gets every RAM slot that scanout does not need. Sits between the VGA timing block, the CPU bus and the framebuffer RAM macro.

Parameters:
FB_WIDTH, 214, pixels per framebuffer line
FB_HEIGHT, 160, framebuffer lines
ADDR_W, 16, pixel address width
PIXEL_W, 3, bits per pixel (R,G,B)

Ports:
clk  in  1  system clock, 50MHz
rst_async_n  in  1  asynchronous active-low reset
vga_addr  in  ADDR_W  scanout pixel address; combinational from the VGA block, stable for >=6 clk per pixel
vga_pixel  out  PIXEL_W  registered pixel for vga_addr
vblank  in  1  high while the VGA block is outside the visible region
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req is high
cpu_addr  in  ADDR_W  CPU pixel address
cpu_wdata  in  PIXEL_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  PIXEL_W  read data; valid while cpu_ack=1
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  PIXEL_W  RAM write data
ram_rdata  in  PIXEL_W  RAM read data, synchronous, 1-cycle latency

Behaviour:
- FB_DEPTH = FB_WIDTH*FB_HEIGHT = 34240. An address >= FB_DEPTH is out-of-range.
- Reset values: vga_pixel=0, cpu_ack=0, cpu_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0. Also last_vga_addr=all-ones, vga_pend=0, slot=NONE.
- Change detect: each cycle, if vga_addr != last_vga_addr, then last_vga_addr<=vga_addr and vga_pend<=1.
- Slot issue, one RAM operation per cycle, in priority order:
  - 1) If vga_pend (or a new change is detected this cycle) and the address is in range: issue a VGA read, slot<=VGA, clear pend.
  - 2) Else if the VGA address is out-of-range and pending: vga_pixel<=0 next cycle, clear pend, no RAM slot used.
  - 3) Else if cpu_req and no CPU op is in flight: issue the CPU op, slot<=CPU_RD or CPU_WR.
  - 4) Else: slot<=NONE.
- Same-cycle conflict: VGA always wins. The CPU waits exactly 1 cycle per VGA fetch.
- vga_pixel latency: updated 2 clk after vga_addr changes (change cycle, then the RAM cycle). Maximum is 2 clk, because VGA holds each pixel for 6 clk.
- CPU write: ram_we=1 in the issue cycle. cpu_ack pulses in the cycle after issue. An out-of-range write drives no ram_we and is still acked.
- CPU read: cpu_rdata<=ram_rdata and cpu_ack=1 in the cycle after issue. An out-of-range read returns 0.
- Back-to-back CPU ops: a new request is accepted in the ack cycle only if cpu_req is still high with a new op. Otherwise re-issue is prevented by a cpu_busy flag, cleared on ack.
- ram_addr/ram_we/ram_wdata are combinational from the issue decision. ram_we=0 in every non-write slot.
- Reset mid-operation: in-flight ops are abandoned, no ack. The first vga_addr seen after reset triggers a fetch, because of the all-ones init.
- Wrap: vga_addr jumping from the last pixel back to 0 is an ordinary change.

Optional Feature:
FB_ARB_VBLANK_WR_EN:
- Defined: CPU writes are issued only while vblank=1 (tear-free). A write request pending when vblank falls waits. A write already issued completes normally. Reads are unaffected.
- Undefined: writes are issued at any time, per the priority rules above. The vblank input is ignored.

Decomposition:
- Package fb_pkg: FB_WIDTH, FB_HEIGHT, FB_DEPTH, ADDR_W, PIXEL_W, typedef pixel_t logic[2:0], typedef fb_addr_t logic[15:0], enum slot_t {SLOT_NONE, SLOT_VGA, SLOT_CPU_RD, SLOT_CPU_WR}.
- No sub-module; the framebuffer RAM macro is instantiated above this block.

Test Plan:
- Reset -> all outputs 0. First vga_addr=0 -> RAM read at addr 0 on cycle 1, vga_pixel=ram_rdata on cycle 2.
- CPU write addr 100, data 3'b101, no VGA activity -> ram_we=1 and ram_addr=100 in the issue cycle, cpu_ack the next cycle. A later CPU read of 100 returns 3'b101 with cpu_ack.
- vga_addr change and cpu_req in the same cycle -> VGA read issued first, CPU op issued the next cycle, cpu_ack delayed 1 cycle versus the no-conflict case.
- vga_addr=40000 (out of range) -> no RAM access, vga_pixel=0. CPU write to 34240 -> ram_we stays 0, cpu_ack still pulses.
- Scanout sweep 0..34239 with addr changing every 6 clk plus continuous CPU writes -> every vga_pixel matches RAM within 2 clk, and no CPU request waits more than 1 cycle.
- With FB_ARB_VBLANK_WR_EN defined: write requested with vblank=0 -> held, no ram_we. Raise vblank -> issued next cycle, then acked.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// Shared framebuffer geometry, pixel/address types and RAM slot encoding
// used by the framebuffer arbiter and its bus interface.
package fb_pkg;
  localparam int FB_WIDTH  = 214;
  localparam int FB_HEIGHT = 160;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 16;
  localparam int PIXEL_W   = 3;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_VGA,
    SLOT_CPU_RD,
    SLOT_CPU_WR
  } slot_t;

  localparam fb_addr_t FB_DEPTH_A = fb_addr_t'(FB_DEPTH);

  function automatic logic in_range(fb_addr_t a);
    return a < FB_DEPTH_A;
  endfunction
endpackage

// File: rtl/fb_arbiter_if.sv
// Scanout, CPU and RAM-side signals of the framebuffer arbiter.
// slave = arbiter side, master = surrounding VGA/CPU/RAM side.
interface fb_arbiter_if;
  import fb_pkg::*;

  fb_addr_t vga_addr;
  pixel_t   vga_pixel;
  logic     vblank;
  logic     cpu_req;
  logic     cpu_we;
  fb_addr_t cpu_addr;
  pixel_t   cpu_wdata;
  logic     cpu_ack;
  pixel_t   cpu_rdata;
  fb_addr_t ram_addr;
  logic     ram_we;
  pixel_t   ram_wdata;
  pixel_t   ram_rdata;

  modport slave (
    input  vga_addr, vblank, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vga_pixel, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vga_addr, vblank, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vga_pixel, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout fetches win, CPU takes idle slots.
// Define FB_ARB_VBLANK_WR_EN to restrict CPU writes to vertical blanking.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_async_n,
  fb_arbiter_if.slave  bus
);

  slot_t    slot, slot_n;
  fb_addr_t last_vga_addr;
  logic     vga_pend, vga_pend_n;
  logic     cpu_busy, cpu_busy_n;
  logic     cpu_oor, cpu_oor_n;
  pixel_t   vga_pixel_q;
  logic     vga_chg, vga_want, vga_zero, wr_ok, ack;
  fb_addr_t addr_n;
  logic     we_n;
  pixel_t   wdata_n;

  assign vga_chg  = (bus.vga_addr != last_vga_addr);
  assign vga_want = vga_pend | vga_chg;
  assign ack      = (slot == SLOT_CPU_RD) || (slot == SLOT_CPU_WR);

`ifdef FB_ARB_VBLANK_WR_EN
  // Tear-free mode: writes wait for blanking, reads go any time.
  assign wr_ok = !bus.cpu_we || bus.vblank;
`else
  logic unused_vblank;
  assign wr_ok         = 1'b1;
  assign unused_vblank = bus.vblank;
`endif

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      slot          <= SLOT_NONE;
      last_vga_addr <= '1;
      vga_pend      <= 1'b0;
      cpu_busy      <= 1'b0;
      cpu_oor       <= 1'b0;
      vga_pixel_q   <= '0;
    end else begin
      slot     <= slot_n;
      vga_pend <= vga_pend_n;
      cpu_busy <= cpu_busy_n;
      cpu_oor  <= cpu_oor_n;
      if (vga_chg)
        last_vga_addr <= bus.vga_addr;
      if (vga_zero)
        vga_pixel_q <= '0;
      else if (slot == SLOT_VGA)
        vga_pixel_q <= bus.ram_rdata;
    end
  end

  always_comb begin
    slot_n     = SLOT_NONE;
    vga_pend_n = vga_want;
    vga_zero   = 1'b0;
    cpu_busy_n = cpu_busy && !ack;
    cpu_oor_n  = cpu_oor;
    addr_n     = '0;
    we_n       = 1'b0;
    wdata_n    = '0;
    if (vga_want && in_range(bus.vga_addr)) begin
      slot_n     = SLOT_VGA;
      vga_pend_n = 1'b0;
      addr_n     = bus.vga_addr;
    end else if (vga_want) begin
      // Off-screen scanout address: blank the pixel without touching RAM.
      vga_pend_n = 1'b0;
      vga_zero   = 1'b1;
    end else if (bus.cpu_req && !cpu_busy && wr_ok) begin
      slot_n     = bus.cpu_we ? SLOT_CPU_WR : SLOT_CPU_RD;
      cpu_busy_n = 1'b1;
      cpu_oor_n  = !in_range(bus.cpu_addr);
      addr_n     = bus.cpu_addr;
      we_n       = bus.cpu_we && in_range(bus.cpu_addr);
      wdata_n    = bus.cpu_wdata;
    end
  end

  // RAM controls are combinational, so hold them quiet while in reset.
  assign bus.ram_addr  = rst_async_n ? addr_n  : '0;
  assign bus.ram_we    = rst_async_n && we_n;
  assign bus.ram_wdata = rst_async_n ? wdata_n : '0;

  // Read data arrives the cycle after issue, the same cycle as the ack.
  assign bus.cpu_ack   = ack;
  assign bus.cpu_rdata = (slot == SLOT_CPU_RD && !cpu_oor) ? bus.ram_rdata : '0;
  assign bus.vga_pixel = vga_pixel_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed scoreboard bench for fb_arbiter with a behavioural 1-cycle RAM.
// Adds a blanking-write test when FB_ARB_VBLANK_WR_EN is defined.
module tb_fb_arbiter;
  import fb_pkg::*;

  typedef struct {
    logic   is_rd;
    pixel_t d;
  } cpu_exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  bit   sweep_done;

  cpu_exp_t cq[$];
  pixel_t   vq[$];
  pixel_t   model[int];
  pixel_t   mem[int];

  fb_arbiter_if bus();

  fb_arbiter dut (
    .clk        (clk),
    .rst_async_n(rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pixel_t pat(int a);
    return pixel_t'(a[2:0] ^ a[5:3] ^ 3'b110);
  endfunction

  function automatic pixel_t exp_px(int a);
    if (a >= FB_DEPTH) return '0;
    return model.exists(a) ? model[a] : pat(a);
  endfunction

  // RAM: synchronous read of the old contents, then write.
  always @(posedge clk) begin
    int a;
    a = int'(bus.ram_addr);
    bus.ram_rdata <= mem.exists(a) ? mem[a] : pat(a);
    if (bus.ram_we) mem[a] = bus.ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_start(input bit we, input int a, input pixel_t d);
    cpu_exp_t e;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = fb_addr_t'(a);
    bus.cpu_wdata = d;
    e.is_rd = !we;
    e.d     = exp_px(a);
    cq.push_back(e);
    if (we && a < FB_DEPTH) model[a] = d;
  endtask

  task automatic cpu_wait(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.cpu_ack && lat < 20);
    check("cpu_ack_seen", bus.cpu_ack, 1);
    bus.cpu_req = 1'b0;
    step();
  endtask

  // Scoreboard consumer: every ack pops one expected CPU result.
  always @(negedge clk) begin
    cpu_exp_t e;
    if (rst_n && bus.cpu_ack) begin
      check("ack_expected", 32'(cq.size() > 0), 1);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        if (e.is_rd) check("cpu_rdata", bus.cpu_rdata, e.d);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.vga_addr  = '0;
    bus.vblank    = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vga_pixel", bus.vga_pixel, 0);
    check("rst_cpu_ack",   bus.cpu_ack, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_ram_we",    bus.ram_we, 0);
    check("rst_ram_addr",  bus.ram_addr, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);

    // First address after reset differs from the all-ones history.
    rst_n = 1'b1;
    vq.push_back(exp_px(0));
    step();
    check("first_px_not_yet", bus.vga_pixel, 0);
    step();
    check("first_px", bus.vga_pixel, vq.pop_front());

    // Uncontended CPU write then read back.
    cpu_start(1, 100, 3'b101);
    #1;
    check("wr_ram_we",    bus.ram_we, 1);
    check("wr_ram_addr",  bus.ram_addr, 100);
    check("wr_ram_wdata", bus.ram_wdata, 3'b101);
    cpu_wait(lat);
    check("wr_lat", lat, 1);
    cpu_start(0, 100, '0);
    cpu_wait(lat);
    check("rd_lat", lat, 1);

    // Scanout change and CPU request in the same cycle.
    bus.vga_addr = 16'd7;
    vq.push_back(exp_px(7));
    cpu_start(0, 100, '0);
    #1;
    check("conf_ram_addr", bus.ram_addr, 7);
    check("conf_ram_we",   bus.ram_we, 0);
    cpu_wait(lat);
    check("conf_lat", lat, 2);
    check("conf_px", bus.vga_pixel, vq.pop_front());

    // Out-of-range scanout and CPU accesses.
    bus.vga_addr = 16'd40000;
    #1;
    check("oor_vga_ram_we", bus.ram_we, 0);
    step();
    step();
    check("oor_vga_px", bus.vga_pixel, 0);
    cpu_start(1, FB_DEPTH, 3'b111);
    #1;
    check("oor_wr_ram_we", bus.ram_we, 0);
    cpu_wait(lat);
    check("oor_wr_lat", lat, 1);
    cpu_start(0, 40000, '0);
    cpu_wait(lat);
    cpu_start(0, FB_DEPTH, '0);
    cpu_wait(lat);
    cpu_start(1, FB_DEPTH - 1, 3'b010);
    cpu_wait(lat);
    cpu_start(0, FB_DEPTH - 1, '0);
    cpu_wait(lat);

    // Scanout sweep (head, tail, wrap to 0) against continuous CPU writes.
    sweep_done = 1'b0;
    fork
      begin
        int a;
        for (int i = 0; i < 1201; i++) begin
          if (i < 600)       a = i;
          else if (i < 1200) a = FB_DEPTH - 1200 + i;
          else               a = 0;
          bus.vga_addr = fb_addr_t'(a);
          vq.push_back(exp_px(a));
          step();
          step();
          check("sweep_px", bus.vga_pixel, vq.pop_front());
          repeat (4) step();
        end
        sweep_done = 1'b1;
      end
      begin
        int k;
        int wl;
        k = 0;
        while (!sweep_done) begin
          cpu_start(1, 20000 + (k % 1000), pixel_t'(k));
          cpu_wait(wl);
          check("sweep_cpu_lat", 32'(wl <= 2), 1);
          k++;
        end
      end
    join

    // Reset during an ack abandons the op; scanout refetches afterwards.
    cpu_start(1, 50, 3'b011);
    step();
    check("pre_rst_ack", bus.cpu_ack, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", bus.cpu_ack, 0);
    check("mid_rst_px",  bus.vga_pixel, 0);
    void'(cq.pop_front());
    bus.cpu_req = 1'b0;
    step();
    rst_n = 1'b1;
    vq.push_back(exp_px(int'(bus.vga_addr)));
    step();
    step();
    check("post_rst_px", bus.vga_pixel, vq.pop_front());

`ifdef FB_ARB_VBLANK_WR_EN
    bus.vblank = 1'b0;
    cpu_start(1, 200, 3'b100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("vb_held_we",  bus.ram_we, 0);
      check("vb_held_ack", bus.cpu_ack, 0);
    end
    bus.vblank = 1'b1;
    #1;
    check("vb_issue_we", bus.ram_we, 1);
    cpu_wait(lat);
    check("vb_lat", lat, 1);
    cpu_start(0, 200, '0);
    cpu_wait(lat);
    bus.vblank = 1'b0;
`endif

    repeat (2) step();
    check("sb_cpu_drained", cq.size(), 0);
    check("sb_vga_drained", vq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
